evt_trigger_sched: RTL and testbench

Sequencer that fires a set of named simulation events one at a time and tracks which handlers have reported running. It sits between a test's cycle-driven stimulus process and its event-handler processes. It replaces ad-hoc "if cycle==N then trigger" chains with a round-robin scheduler, a sticky triggered mask and a per-event acknowledge timeout. It is used by timing regressions to check event ordering and delivery under both clock edges.

---
 rtl/evt_trigger_sched_if.sv | 29 ++
 rtl/evt_trigger_sched.sv | 160 ++++++++++++++++
 tb/tb_evt_trigger_sched.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/evt_trigger_sched_if.sv
// evt_trigger_sched_if -- stimulus/handler bundle for the event trigger sequencer. Rev 1.0
`default_nettype none

interface evt_trigger_sched_if #(
  parameter int NUM_EVT = 2,
  parameter int CNT_W   = 8
);
  logic               start;
  logic [NUM_EVT-1:0] evt_req;
  logic [NUM_EVT-1:0] evt_ack;
  logic [NUM_EVT-1:0] evt_fire;
  logic [NUM_EVT-1:0] triggered;
  logic [CNT_W-1:0]   cyc;
  logic               busy;
  logic               done;
  logic               error;

  modport slave (
    input  start, evt_req, evt_ack,
    output evt_fire, triggered, cyc, busy, done, error
  );

  modport master (
    output start, evt_req, evt_ack,
    input  evt_fire, triggered, cyc, busy, done, error
  );
endinterface

`default_nettype wire

// File: rtl/evt_trigger_sched.sv
// evt_trigger_sched -- round-robin event trigger sequencer with sticky ack mask and ack timeout. Rev 1.0
`default_nettype none

module evt_trigger_sched #(
  parameter int NUM_EVT = 2,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  evt_trigger_sched_if.slave bus
);

  localparam int         SEL_W    = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_FIRE = 3'd2,
    S_WAIT = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_EVT-1:0] pend_q, pend_d;
  logic [NUM_EVT-1:0] trig_q, trig_d;
  logic [NUM_EVT-1:0] fire_q, fire_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic [7:0]         timer_q, timer_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               busy;
  logic [NUM_EVT-1:0] sel_oh;
  logic [SEL_W-1:0]   pick;
  logic [SEL_W-1:0]   idx;
  logic               found;
  logic [SEL_W-1:0]   next_rr;

  assign busy    = (state_q == S_ARB) || (state_q == S_FIRE) || (state_q == S_WAIT);
  assign next_rr = SEL_W'((int'(sel_q) + 1) % NUM_EVT);

  always_comb begin
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
  end

  // Rotating search: first pending bit at or above rr_q, wrapping to 0.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_EVT; i++) begin
      idx = SEL_W'((int'(rr_q) + i) % NUM_EVT);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    trig_d  = trig_q;
    fire_d  = '0;
    sel_d   = sel_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    cyc_d   = cyc_q;
    done_d  = done_q;
    err_d   = err_q;

    if (busy) begin
      pend_d = pend_q | bus.evt_req;
      if (cyc_q != {CNT_W{1'b1}}) cyc_d = cyc_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pend_d  = bus.evt_req;
          trig_d  = '0;
          cyc_d   = '0;
          done_d  = 1'b0;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (pend_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          sel_d   = pick;
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        // A request arriving in this cycle re-queues the event being fired.
        fire_d  = sel_oh;
        pend_d  = (pend_q & ~sel_oh) | bus.evt_req;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.evt_ack[sel_q]) begin
          trig_d  = trig_q | sel_oh;
          rr_d    = next_rr;
          state_d = S_ARB;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      trig_q  <= '0;
      fire_q  <= '0;
      sel_q   <= '0;
      rr_q    <= '0;
      timer_q <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      trig_q  <= trig_d;
      fire_q  <= fire_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.evt_fire  = fire_q;
  assign bus.triggered = trig_q;
  assign bus.cyc       = cyc_q;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.error     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_evt_trigger_sched.sv
// tb_evt_trigger_sched -- directed and randomized checks of evt_trigger_sched against a behavioural model. Rev 1.0
`default_nettype none

module tb_evt_trigger_sched;

  localparam int NUM_EVT = 2;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 4;
  localparam int CYC_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   ack_mode = 0;  // 0 none, 1 echo fire, 2 mostly-ack random, 3 rarely-ack random

  always #5 clk = ~clk;

  evt_trigger_sched_if #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W)) bus ();

  evt_trigger_sched #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model: phase 0 idle, 1 choosing, 2 launching, 3 awaiting ack, 4 dead.
  int                 m_ph    = 0;
  logic [NUM_EVT-1:0] m_pend  = '0;
  logic [NUM_EVT-1:0] m_trig  = '0;
  logic [NUM_EVT-1:0] m_fire  = '0;
  int                 m_sel   = 0;
  int                 m_rr    = 0;
  int                 m_wait  = 0;
  int                 m_cyc   = 0;
  logic               m_done  = 1'b0;
  logic               m_err   = 1'b0;

  task automatic model_step();
    logic [NUM_EVT-1:0] req, ack, old, bit_sel;
    req    = bus.evt_req;
    ack    = bus.evt_ack;
    old    = m_pend;
    m_fire = '0;
    if (rst) begin
      m_ph = 0; m_pend = '0; m_trig = '0; m_sel = 0; m_rr = 0;
      m_wait = 0; m_cyc = 0; m_done = 1'b0; m_err = 1'b0;
      return;
    end
    if (m_ph >= 1 && m_ph <= 3) begin
      m_pend = old | req;
      if (m_cyc < CYC_MAX) m_cyc = m_cyc + 1;
    end
    bit_sel = NUM_EVT'(1) << m_sel;
    case (m_ph)
      0: if (bus.start) begin
           m_pend = req; m_trig = '0; m_cyc = 0; m_done = 1'b0; m_ph = 1;
         end
      1: if (old == '0) begin
           m_done = 1'b1; m_ph = 0;
         end else begin
           for (int i = 0; i < NUM_EVT; i++) begin
             if (old[(m_rr + i) % NUM_EVT]) begin
               m_sel = (m_rr + i) % NUM_EVT;
               break;
             end
           end
           m_ph = 2;
         end
      2: begin
           m_fire = bit_sel;
           m_pend = (old & ~bit_sel) | req;
           m_wait = 0;
           m_ph   = 3;
         end
      3: if (ack[m_sel]) begin
           m_trig = m_trig | bit_sel;
           m_rr   = (m_sel + 1) % NUM_EVT;
           m_ph   = 1;
         end else if (m_wait == TIMEOUT - 1) begin
           m_err = 1'b1; m_ph = 4;
         end else begin
           m_wait = m_wait + 1;
         end
      default: ;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!bus.done && n < 100) begin
      step();
      n++;
    end
    if (!bus.done) begin
      checks++;
      failures++;
      $display("FAIL %s done never rose actual=0 required=1", nm);
    end
  endtask

  task automatic start_run(input logic [NUM_EVT-1:0] req);
    bus.start   = 1'b1;
    bus.evt_req = req;
    step();
    bus.start   = 1'b0;
    bus.evt_req = '0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Acknowledge driver; a value set here is sampled at the next rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (ack_mode)
      1:       bus.evt_ack = bus.evt_fire;
      2:       bus.evt_ack = ~(NUM_EVT'($urandom) & NUM_EVT'($urandom) & NUM_EVT'($urandom));
      3:       bus.evt_ack = NUM_EVT'($urandom) & NUM_EVT'($urandom);
      default: bus.evt_ack = '0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    chk("cmp_evt_fire",  32'(bus.evt_fire),  32'(m_fire));
    chk("cmp_triggered", 32'(bus.triggered), 32'(m_trig));
    chk("cmp_cyc",       32'(bus.cyc),       32'(m_cyc));
    chk("cmp_busy",      32'(bus.busy),      32'(m_ph >= 1 && m_ph <= 3));
    chk("cmp_done",      32'(bus.done),      32'(m_done));
    chk("cmp_error",     32'(bus.error),     32'(m_err));
  end

  initial begin
    bus.start   = 1'b0;
    bus.evt_req = '0;
    bus.evt_ack = '0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_fire", 32'(bus.evt_fire), 32'd0);
    chk("rst_trig", 32'(bus.triggered), 32'd0);
    chk("rst_cyc", 32'(bus.cyc), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    rst = 1'b0;
    step();

    // Basic run: both events, each acked at the first wait edge.
    ack_mode = 1;
    start_run(2'b11);
    chk("basic_busy", 32'(bus.busy), 32'd1);
    step(); step();
    chk("basic_fire0", 32'(bus.evt_fire), 32'h1);
    step();
    chk("basic_trig0", 32'(bus.triggered), 32'h1);
    step(); step();
    chk("basic_fire1", 32'(bus.evt_fire), 32'h2);
    step();
    chk("basic_trig1", 32'(bus.triggered), 32'h3);
    step();
    chk("basic_done", 32'(bus.done), 32'd1);
    chk("basic_cyc", 32'(bus.cyc), 32'd7);
    chk("basic_busy_off", 32'(bus.busy), 32'd0);
    chk("basic_error", 32'(bus.error), 32'd0);

    // Round robin: a single-event run leaves the pointer at event 1.
    start_run(2'b01);
    wait_done("rr_prep");
    start_run(2'b11);
    step(); step();
    chk("rr_first_fire", 32'(bus.evt_fire), 32'h2);
    step(); step(); step();
    chk("rr_second_fire", 32'(bus.evt_fire), 32'h1);
    wait_done("rr_run");
    chk("rr_trig", 32'(bus.triggered), 32'h3);

    // Empty run.
    start_run(2'b00);
    chk("empty_done_clr", 32'(bus.done), 32'd0);
    step();
    chk("empty_done", 32'(bus.done), 32'd1);
    chk("empty_trig", 32'(bus.triggered), 32'd0);
    chk("empty_fire", 32'(bus.evt_fire), 32'd0);

    // Late request while event 0 awaits its ack.
    start_run(2'b01);
    step(); step();
    bus.evt_req = 2'b10;
    step();
    bus.evt_req = 2'b00;
    wait_done("late_run");
    chk("late_trig", 32'(bus.triggered), 32'h3);

    // Timeout with the ack withheld.
    ack_mode = 0;
    start_run(2'b01);
    repeat (5) step();
    chk("tmo_err_early", 32'(bus.error), 32'd0);
    step();
    chk("tmo_err", 32'(bus.error), 32'd1);
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    start_run(2'b11);
    step();
    chk("tmo_start_ign_busy", 32'(bus.busy), 32'd0);
    chk("tmo_start_ign_err", 32'(bus.error), 32'd1);
    chk("tmo_start_ign_fire", 32'(bus.evt_fire), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("tmo_rst_err", 32'(bus.error), 32'd0);
    chk("tmo_rst_cyc", 32'(bus.cyc), 32'd0);

    // Reset while in FIRE truncates the pulse; a fresh run completes.
    ack_mode = 1;
    start_run(2'b11);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_fire", 32'(bus.evt_fire), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_trig", 32'(bus.triggered), 32'd0);
    start_run(2'b11);
    wait_done("midrst_rerun");
    chk("midrst_rerun_trig", 32'(bus.triggered), 32'h3);
    chk("midrst_rerun_err", 32'(bus.error), 32'd0);

    // Counter saturation under a never-ending stream of requests.
    start_run(2'b11);
    bus.evt_req = 2'b11;
    repeat (300) step();
    chk("sat_cyc", 32'(bus.cyc), 32'(CYC_MAX));
    chk("sat_busy", 32'(bus.busy), 32'd1);
    bus.evt_req = '0;
    wait_done("sat_drain");
    chk("sat_cyc_hold", 32'(bus.cyc), 32'(CYC_MAX));

    // Randomized traffic with bursts of ack drought.
    for (int c = 0; c < 4000; c++) begin
      ack_mode    = (((c / 500) % 4) == 3) ? 3 : 2;
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.evt_req = NUM_EVT'($urandom) & NUM_EVT'($urandom) & NUM_EVT'($urandom);
      rst         = ($urandom_range(0, 299) == 0) || (m_ph == 4 && $urandom_range(0, 15) == 0);
      step();
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.evt_req = '0;
    ack_mode  = 0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
